// File: rtl/pwm_sample_feeder.sv
// Sample FIFO feeding a PWM duty register: volume-scales each sample about midscale
// and issues one duty update per SAMPLE_PERIOD clocks, holding the last value on underflow.
module pwm_sample_feeder #(
  parameter int DEPTH         = 16,
  parameter int SAMPLE_PERIOD = 2083
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [7:0]               sample_in,
  input  logic                     sample_valid_in,
  output logic                     sample_ready_out,
  input  logic [3:0]               vol_in,
  output logic [7:0]               dc_out,
  output logic                     tick_out,
  output logic                     underflow_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);

  // Gain is (vol+1)/16 applied to the signed offset from midscale; the floor shift
  // keeps the result inside [0,255] for every sample/volume pair.
  function automatic logic [DATA_W-1:0] scale_sample(input logic [DATA_W-1:0] smp,
                                                     input logic [3:0]        vol);
    logic signed [8:0]  s;
    logic signed [5:0]  g;
    logic signed [12:0] p;
    logic signed [12:0] sh;
    s  = $signed({1'b0, smp}) - 9'sd128;
    g  = $signed({2'b00, vol}) + 6'sd1;
    p  = 13'(s) * 13'(g);
    sh = p >>> 4;
    return DATA_W'(sh + 13'sd128);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [DATA_W-1:0] dc_q, dc_d;
  logic              tick_q, tick_d;
  logic              uf_q, uf_d;

  logic full;
  logic tick_cyc;
  logic push;
  logic pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    tick_cyc = (pcnt_q == PCNT_W'(SAMPLE_PERIOD - 1));
    push     = sample_valid_in && !full;
    // Pop sees only the registered occupancy, so a same-cycle push cannot bypass.
    pop      = tick_cyc && (count_q != '0);

    pcnt_d   = tick_cyc ? '0 : pcnt_q + PCNT_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    dc_d   = pop ? scale_sample(mem_q[rd_ptr_q], vol_in) : dc_q;
    tick_d = pop;
    uf_d   = tick_cyc && !pop;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pcnt_q   <= '0;
      dc_q     <= DATA_W'(128);
      tick_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      dc_q     <= dc_d;
      tick_q   <= tick_d;
      uf_q     <= uf_d;
    end
  end

  // Storage is data-only; occupancy and pointers decide what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign sample_ready_out = !full;
  assign dc_out           = dc_q;
  assign tick_out         = tick_q;
  assign underflow_out    = uf_q;
  assign count_out        = count_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Bench for pwm_sample_feeder: directed scenarios plus randomized traffic against a
// queue-based reference model that counts edges since reset to place the ticks.
module tb_pwm_sample_feeder;

  localparam int DEPTH = 4;
  localparam int P     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       valid = 1'b0;
  logic       ready;
  logic [3:0] vol = 4'd15;
  logic [7:0] dc;
  logic       tick;
  logic       uf;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  int q[$];
  int ecount = 0;
  int exp_dc = 128;
  bit exp_tick = 1'b0;
  bit exp_uf = 1'b0;

  pwm_sample_feeder #(.DEPTH(DEPTH), .SAMPLE_PERIOD(P)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .sample_in       (sample),
    .sample_valid_in (valid),
    .sample_ready_out(ready),
    .vol_in          (vol),
    .dc_out          (dc),
    .tick_out        (tick),
    .underflow_out   (uf),
    .count_out       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_dc(int smp, int v);
    int s, p, f;
    s = smp - 128;
    p = s * (v + 1);
    if (p >= 0) f = p / 16;
    else        f = -((-p + 15) / 16);
    return 128 + f;
  endfunction

  task automatic model_reset();
    q.delete();
    ecount   = 0;
    exp_dc   = 128;
    exp_tick = 1'b0;
    exp_uf   = 1'b0;
  endtask

  // One clock edge: the model decides acceptance and pop from pre-edge state.
  task automatic step();
    bit acc;
    int smp_now, vol_now;
    acc     = valid && (q.size() < DEPTH);
    smp_now = int'(sample);
    vol_now = int'(vol);
    @(posedge clk);
    ecount++;
    exp_tick = 1'b0;
    exp_uf   = 1'b0;
    if (ecount % P == 0) begin
      if (q.size() > 0) begin
        exp_dc   = ref_dc(q.pop_front(), vol_now);
        exp_tick = 1'b1;
      end else begin
        exp_uf = 1'b1;
      end
    end
    if (acc) q.push_back(smp_now);
    #1;
  endtask

  task automatic to_next_period(output int stray);
    stray = 0;
    do begin
      step();
      if ((ecount % P != 0) && (tick || uf)) stray++;
    end while (ecount % P != 0);
  endtask

  task automatic push_one(input int v);
    sample = 8'(v);
    valid  = 1'b1;
    step();
    valid  = 1'b0;
  endtask

  task automatic test_reset();
    int stray;
    valid = 1'b0;
    vol   = 4'd15;
    model_reset();
    @(posedge clk); #1;
    checks++; if (dc !== 8'd128) begin failures++; $display("FAIL reset_dc: got %0d want 128", dc); end
    checks++; if (count !== 3'd0 || ready !== 1'b1) begin failures++; $display("FAIL reset_fifo: count=%0d ready=%0b want 0/1", count, ready); end
    checks++; if (tick !== 1'b0 || uf !== 1'b0) begin failures++; $display("FAIL reset_pulses: tick=%0b uf=%0b want 0/0", tick, uf); end
    rst_n = 1'b1;

    push_one(200);
    to_next_period(stray);
    checks++; if (dc !== 8'd200 || tick !== 1'b1) begin failures++; $display("FAIL pre_reset_dc: got %0d tick=%0b want 200/1", dc, tick); end
    push_one(1); push_one(2); push_one(3);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pre_reset_count: got %0d want 3", count); end

    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (dc !== 8'd128) begin failures++; $display("FAIL async_reset_dc: got %0d want 128", dc); end
    checks++; if (count !== 3'd0 || ready !== 1'b1) begin failures++; $display("FAIL async_reset_fifo: count=%0d ready=%0b want 0/1", count, ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < P; i++) begin
      step();
      checks++;
      if ((tick || uf) !== (i == P - 1)) begin
        failures++; $display("FAIL first_tick_timing: edge %0d pulse=%0b want %0b", i + 1, tick || uf, i == P - 1);
      end
    end
    checks++; if (uf !== 1'b1 || dc !== 8'd128) begin failures++; $display("FAIL first_tick_empty: uf=%0b dc=%0d want 1/128", uf, dc); end
  endtask

  task automatic test_gain_order();
    int want[3] = '{200, 50, 128};
    int stray;
    vol = 4'd15;
    push_one(200); push_one(50); push_one(128);
    for (int i = 0; i < 3; i++) begin
      to_next_period(stray);
      checks++; if (stray !== 0) begin failures++; $display("FAIL gain_spacing: %0d stray pulses want 0", stray); end
      checks++;
      if (tick !== 1'b1 || dc !== 8'(want[i]) || dc !== 8'(exp_dc)) begin
        failures++; $display("FAIL gain_order[%0d]: dc=%0d tick=%0b want %0d/1", i, dc, tick, want[i]);
      end
    end
  endtask

  task automatic test_volume();
    int want[2] = '{191, 64};
    int stray;
    vol = 4'd7;
    push_one(255); push_one(0);
    for (int i = 0; i < 2; i++) begin
      to_next_period(stray);
      checks++;
      if (tick !== 1'b1 || dc !== 8'(want[i]) || dc !== 8'(exp_dc)) begin
        failures++; $display("FAIL volume[%0d]: dc=%0d tick=%0b want %0d/1", i, dc, tick, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int stray;
    vol = 4'd15;
    valid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      sample = 8'(v);
      step();
    end
    checks++; if (ready !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL full_state: ready=%0b count=%0d want 0/4", ready, count); end
    sample = 8'd5;
    to_next_period(stray);
    checks++; if (tick !== 1'b1 || dc !== 8'd1 || ready !== 1'b1 || count !== 3'd3) begin
      failures++; $display("FAIL full_pop: dc=%0d ready=%0b count=%0d want 1/1/3", dc, ready, count);
    end
    step();
    checks++; if (count !== 3'd4 || ready !== 1'b0) begin failures++; $display("FAIL accept_5: count=%0d ready=%0b want 4/0", count, ready); end
    sample = 8'd6;
    to_next_period(stray);
    checks++; if (dc !== 8'd2) begin failures++; $display("FAIL bp_order[2]: got %0d want 2", dc); end
    step();
    valid = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      to_next_period(stray);
      checks++; if (tick !== 1'b1 || dc !== 8'(k)) begin failures++; $display("FAIL bp_order[%0d]: dc=%0d tick=%0b want %0d/1", k, dc, tick, k); end
    end
  endtask

  task automatic test_underflow();
    int stray;
    vol = 4'd15;
    push_one(77);
    to_next_period(stray);
    checks++; if (dc !== 8'd77 || tick !== 1'b1) begin failures++; $display("FAIL uf_last: dc=%0d tick=%0b want 77/1", dc, tick); end
    for (int i = 0; i < 3; i++) begin
      to_next_period(stray);
      checks++;
      if (uf !== 1'b1 || tick !== 1'b0 || dc !== 8'd77 || stray !== 0) begin
        failures++; $display("FAIL underflow[%0d]: uf=%0b tick=%0b dc=%0d stray=%0d want 1/0/77/0", i, uf, tick, dc, stray);
      end
    end
  endtask

  task automatic test_push_tick_empty();
    int stray;
    vol = 4'd15;
    while (ecount % P != P - 1) step();
    push_one(99);
    checks++; if (uf !== 1'b1 || tick !== 1'b0 || count !== 3'd1 || dc !== 8'd77) begin
      failures++; $display("FAIL tick_push_uf: uf=%0b tick=%0b count=%0d dc=%0d want 1/0/1/77", uf, tick, count, dc);
    end
    step();
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL tick_push_hold: count=%0d want 1", count); end
    to_next_period(stray);
    checks++; if (tick !== 1'b1 || dc !== 8'd99 || count !== 3'd0) begin
      failures++; $display("FAIL tick_push_next: tick=%0b dc=%0d count=%0d want 1/99/0", tick, dc, count);
    end
  endtask

  task automatic test_random();
    int rate;
    rate = 1;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) rate = int'($urandom_range(0, 3));
      valid  = ($urandom_range(0, 3) < rate);
      sample = 8'($urandom_range(0, 255));
      vol    = 4'($urandom_range(0, 15));
      step();
      checks++;
      if (dc !== 8'(exp_dc) || tick !== exp_tick || uf !== exp_uf ||
          count !== 3'(q.size()) || ready !== (q.size() < DEPTH) || (tick && uf)) begin
        failures++;
        $display("FAIL random[%0d]: dc=%0d tick=%0b uf=%0b count=%0d ready=%0b want dc=%0d tick=%0b uf=%0b count=%0d",
                 n, dc, tick, uf, count, ready, exp_dc, exp_tick, exp_uf, q.size());
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gain_order();
    test_volume();
    test_backpressure();
    test_underflow();
    test_push_tick_empty();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
